// File: rtl/serial_divide_pkg.sv
// Shared types and sizing helpers for the serial restoring divider.
package serial_divide_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } divStateT;

    // Number of quotient bits produced, one per enabled step.
    function automatic int calcIterCount(input int m, input int r, input int s);
        return m + r - s;
    endfunction

    // The remainder keeps one guard bit above the divisor width.
    function automatic int calcRemWidth(input int n);
        return n + 1;
    endfunction

endpackage

// File: rtl/serial_divide_step.sv
// One restoring-division step: shift a dividend bit into the remainder and
// subtract the divisor when it fits. Purely combinational.
module serial_divide_step #(
    parameter int N_PP = 8
) (
    input  logic [N_PP:0]   i_remainder,
    input  logic            i_shiftBit,
    input  logic [N_PP-1:0] i_divisor,
    output logic [N_PP:0]   o_remainder,
    output logic            o_quotientBit
);

    logic [N_PP+1:0] w_partial;
    logic [N_PP:0]   w_difference;

    assign w_partial    = {i_remainder, i_shiftBit};
    assign w_difference = w_partial[N_PP:0] - {1'b0, i_divisor};

    // Compare the widened partial remainder so no carried-out bit is lost.
    always_comb begin
        o_quotientBit = 1'b0;
        o_remainder   = w_partial[N_PP:0];
        if (w_partial >= {2'b00, i_divisor}) begin
            o_quotientBit = 1'b1;
            o_remainder   = w_difference;
        end
    end

endmodule

// File: rtl/serial_divide_uu.sv
// Unsigned serial restoring divider, one quotient bit per enabled clock,
// MSB first. Result is floor(dividend * 2^R_PP / divisor) truncated to
// M_PP+R_PP-S_PP bits, saturating to all ones when it would not fit.
// Optional feature: define SERIAL_DIVIDE_ERR_EN to add the err_o flag.
module serial_divide_uu
    import serial_divide_pkg::*;
#(
    parameter int M_PP           = 16,
    parameter int N_PP           = 8,
    parameter int R_PP           = 0,
    parameter int S_PP           = 0,
    parameter int COUNT_WIDTH_PP = 5
) (
    input  logic                        clk_i,
    input  logic                        rst_n_i,
    input  logic                        clk_en_i,
    input  logic                        divide_i,
    input  logic [M_PP-1:0]             dividend_i,
    input  logic [N_PP-1:0]             divisor_i,
    output logic [M_PP+R_PP-S_PP-1:0]   quotient_o,
    output logic                        done_o
`ifdef SERIAL_DIVIDE_ERR_EN
    ,
    output logic                        err_o
`endif
);

    localparam int Q_LP     = calcIterCount(M_PP, R_PP, S_PP);
    localparam int REM_W_LP = calcRemWidth(N_PP);
    localparam int EXT_W_LP = M_PP + R_PP + N_PP + 1;
    localparam logic [COUNT_WIDTH_PP-1:0] LAST_COUNT_LP = COUNT_WIDTH_PP'(Q_LP - 1);

    divStateT                  r_state;
    divStateT                  w_nextState;
    logic [Q_LP-1:0]           r_dividend;
    logic [Q_LP-1:0]           r_quotShift;
    logic [Q_LP-1:0]           r_quotient;
    logic [Q_LP-1:0]           w_quotNext;
    logic [N_PP-1:0]           r_divisor;
    logic [REM_W_LP-1:0]       r_remainder;
    logic [REM_W_LP-1:0]       w_stepRemainder;
    logic [COUNT_WIDTH_PP-1:0] r_count;
    logic                      r_done;
    logic                      r_saturate;
    logic                      w_quotientBit;
    logic                      w_lastStep;
    logic                      w_overflow;
    logic [EXT_W_LP-1:0]       w_extDividend;
    logic [EXT_W_LP-1:0]       w_topBits;

    // The fraction bits are zeros appended below the dividend; the skipped
    // top S_PP bits go straight into the remainder at start.
    assign w_extDividend = EXT_W_LP'(dividend_i) << R_PP;
    assign w_topBits     = w_extDividend >> Q_LP;
    // Quotient does not fit in Q bits (also true for a zero divisor).
    assign w_overflow    = (w_topBits >= EXT_W_LP'(divisor_i));

    assign w_lastStep = (r_state == BUSY) && (r_count == LAST_COUNT_LP);
    assign w_quotNext = (r_quotShift << 1) | Q_LP'(w_quotientBit);

    serial_divide_step #(
        .N_PP(N_PP)
    ) u_step (
        .i_remainder  (r_remainder),
        .i_shiftBit   (r_dividend[Q_LP-1]),
        .i_divisor    (r_divisor),
        .o_remainder  (w_stepRemainder),
        .o_quotientBit(w_quotientBit)
    );

    // FSM state register, advancing only on enabled edges.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= IDLE;
        end else if (clk_en_i) begin
            r_state <= w_nextState;
        end
    end

    // Next state: a start always wins, otherwise leave BUSY after the last step.
    always_comb begin
        w_nextState = r_state;
        if (divide_i) begin
            w_nextState = BUSY;
        end else if (w_lastStep) begin
            w_nextState = IDLE;
        end
    end

    // Operand capture, shift/subtract iteration and result publication.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_dividend  <= '0;
            r_divisor   <= '0;
            r_remainder <= '0;
            r_quotShift <= '0;
            r_quotient  <= '0;
            r_count     <= '0;
            r_saturate  <= 1'b0;
            r_done      <= 1'b0;
        end else if (clk_en_i) begin
            if (divide_i) begin
                r_dividend  <= w_extDividend[Q_LP-1:0];
                r_divisor   <= divisor_i;
                r_remainder <= w_topBits[REM_W_LP-1:0];
                r_quotShift <= '0;
                r_count     <= '0;
                r_saturate  <= w_overflow;
                r_done      <= 1'b0;
            end else if (r_state == BUSY) begin
                r_dividend  <= r_dividend << 1;
                r_remainder <= w_stepRemainder;
                r_quotShift <= w_quotNext;
                r_count     <= r_count + COUNT_WIDTH_PP'(1);
                if (w_lastStep) begin
                    r_quotient <= r_saturate ? '1 : w_quotNext;
                    r_done     <= 1'b1;
                end
            end
        end
    end

    assign quotient_o = r_quotient;
    assign done_o     = r_done;

`ifdef SERIAL_DIVIDE_ERR_EN
    logic r_err;

    // Error flag rises with done on saturation and clears on the next start.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_err <= 1'b0;
        end else if (clk_en_i) begin
            if (divide_i) begin
                r_err <= 1'b0;
            end else if (w_lastStep) begin
                r_err <= r_saturate;
            end
        end
    end

    assign err_o = r_err;
`endif

endmodule

// File: tb/tb_serial_divide_uu.sv
// Directed bench for serial_divide_uu: default, R_PP=4 and S_PP=8 instances
// share one stimulus bus; expected quotients are hand-computed constants.
module tb_serial_divide_uu;

    logic        clk = 1'b0;
    logic        rstN = 1'b1;
    logic        clkEn = 1'b1;
    logic        divide = 1'b0;
    logic [15:0] dividend = '0;
    logic [7:0]  divisor = '0;

    logic [15:0] qDef;
    logic [19:0] qR;
    logic [7:0]  qS;
    logic        doneDef, doneR, doneS;
`ifdef SERIAL_DIVIDE_ERR_EN
    logic        errDef, errR, errS;
`endif

    int checkCount = 0;
    int errorCount = 0;

    always #5 clk = ~clk;

    serial_divide_uu dutDef (
        .clk_i(clk), .rst_n_i(rstN), .clk_en_i(clkEn), .divide_i(divide),
        .dividend_i(dividend), .divisor_i(divisor),
        .quotient_o(qDef), .done_o(doneDef)
`ifdef SERIAL_DIVIDE_ERR_EN
        , .err_o(errDef)
`endif
    );

    serial_divide_uu #(.R_PP(4)) dutR (
        .clk_i(clk), .rst_n_i(rstN), .clk_en_i(clkEn), .divide_i(divide),
        .dividend_i(dividend), .divisor_i(divisor),
        .quotient_o(qR), .done_o(doneR)
`ifdef SERIAL_DIVIDE_ERR_EN
        , .err_o(errR)
`endif
    );

    serial_divide_uu #(.S_PP(8)) dutS (
        .clk_i(clk), .rst_n_i(rstN), .clk_en_i(clkEn), .divide_i(divide),
        .dividend_i(dividend), .divisor_i(divisor),
        .quotient_o(qS), .done_o(doneS)
`ifdef SERIAL_DIVIDE_ERR_EN
        , .err_o(errS)
`endif
    );

    // Count one comparison and report it when it disagrees.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: actual=%0d expected=%0d", tag, actual, expected);
        end
    endtask

    // Pulse divide for one clock around a rising edge, with new operands.
    task automatic applyStimulus(input logic [15:0] dvd, input logic [7:0] dvs);
        @(negedge clk);
        divide   = 1'b1;
        dividend = dvd;
        divisor  = dvs;
        @(negedge clk);
        divide   = 1'b0;
    endtask

    // Wait for done of the selected instance, counting enabled edges and
    // watching that the default quotient stays put while busy.
    task automatic waitDone(input int sel, input int limit, input logic toggle,
                            output int edges, output int clocks, output logic heldOk);
        logic [15:0] held;
        logic        d;
        logic        found;
        held   = qDef;
        heldOk = 1'b1;
        found  = 1'b0;
        edges  = 0;
        clocks = 0;
        for (int k = 0; k < limit; k++) begin
            if (toggle) clkEn = ~clkEn;
            @(posedge clk);
            clocks++;
            if (clkEn) edges++;
            #1;
            case (sel)
                0:       d = doneDef;
                1:       d = doneR;
                default: d = doneS;
            endcase
            if (d) begin
                found = 1'b1;
                break;
            end
            if (qDef !== held) heldOk = 1'b0;
            @(negedge clk);
        end
        if (!found) edges = 999;
    endtask

    int   edges;
    int   clocks;
    logic heldOk;

    initial begin
        // Reset state
        #3 rstN = 1'b0;
        #1;
        checkOutput("rstQuot", qDef, 0);
        checkOutput("rstDone", doneDef, 0);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rstQuotR", qR, 0);
        checkOutput("rstDoneS", doneS, 0);
`ifdef SERIAL_DIVIDE_ERR_EN
        checkOutput("rstErr", errDef, 0);
`endif
        @(negedge clk);
        rstN = 1'b1;

        // 0/1 latency
        applyStimulus(16'd0, 8'd1);
        checkOutput("busyDone0", doneDef, 0);
        waitDone(0, 40, 1'b0, edges, clocks, heldOk);
        checkOutput("lat0", edges, 16);
        checkOutput("quot0", qDef, 0);

        // 1000/7
        applyStimulus(16'd1000, 8'd7);
        waitDone(0, 40, 1'b0, edges, clocks, heldOk);
        checkOutput("lat1000_7", edges, 16);
        checkOutput("quot1000_7", qDef, 142);
        checkOutput("hold1000_7", heldOk, 1);

        // 65535/1
        applyStimulus(16'd65535, 8'd1);
        checkOutput("busyDone1", doneDef, 0);
        waitDone(0, 40, 1'b0, edges, clocks, heldOk);
        checkOutput("quot65535_1", qDef, 65535);
        checkOutput("hold65535_1", heldOk, 1);

        // 65535/255
        applyStimulus(16'd65535, 8'd255);
        waitDone(0, 40, 1'b0, edges, clocks, heldOk);
        checkOutput("quot65535_255", qDef, 257);
        checkOutput("hold65535_255", heldOk, 1);

        // divide by zero
        applyStimulus(16'd100, 8'd0);
        waitDone(0, 40, 1'b0, edges, clocks, heldOk);
        checkOutput("quotDiv0", qDef, 16'hFFFF);
`ifdef SERIAL_DIVIDE_ERR_EN
        checkOutput("errDiv0", errDef, 1);
`endif

        // fractional bits: 7/2 with R_PP=4
        applyStimulus(16'd7, 8'd2);
`ifdef SERIAL_DIVIDE_ERR_EN
        checkOutput("errClear", errDef, 0);
`endif
        waitDone(1, 40, 1'b0, edges, clocks, heldOk);
        checkOutput("latR", edges, 20);
        checkOutput("quotR7_2", qR, 56);
        checkOutput("quotDef7_2", qDef, 3);

        // skipped bits: 300/2 with S_PP=8
        applyStimulus(16'd300, 8'd2);
        waitDone(2, 40, 1'b0, edges, clocks, heldOk);
        checkOutput("latS", edges, 8);
        checkOutput("quotS300_2", qS, 150);
`ifdef SERIAL_DIVIDE_ERR_EN
        checkOutput("errS300_2", errS, 0);
`endif

        // S_PP overflow saturates
        applyStimulus(16'd1000, 8'd2);
        waitDone(2, 40, 1'b0, edges, clocks, heldOk);
        checkOutput("quotSsat", qS, 8'hFF);
`ifdef SERIAL_DIVIDE_ERR_EN
        checkOutput("errSsat", errS, 1);
`endif

        // clock enable toggling every cycle while busy
        applyStimulus(16'd1000, 8'd7);
        waitDone(0, 80, 1'b1, edges, clocks, heldOk);
        checkOutput("latEnEdges", edges, 16);
        checkOutput("latEnClocks", clocks, 32);
        checkOutput("quotEn", qDef, 142);
        clkEn = 1'b1;

        // start request while disabled is ignored
        clkEn = 1'b0;
        applyStimulus(16'd5, 8'd1);
        clkEn = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("ignDone", doneDef, 1);
        checkOutput("ignQuot", qDef, 142);

        // restart mid-division
        applyStimulus(16'd1000, 8'd7);
        repeat (5) @(posedge clk);
        applyStimulus(16'd200, 8'd3);
        waitDone(0, 40, 1'b0, edges, clocks, heldOk);
        checkOutput("latRestart", edges, 16);
        checkOutput("quotRestart", qDef, 66);
        checkOutput("holdRestart", heldOk, 1);
        checkOutput("quotSRestart", qS, 66);

        // reset mid-division
        applyStimulus(16'd65535, 8'd1);
        repeat (5) @(posedge clk);
        #2 rstN = 1'b0;
        #1;
        checkOutput("midRstQuot", qDef, 0);
        checkOutput("midRstDone", doneDef, 0);
        checkOutput("midRstQuotS", qS, 0);
        @(negedge clk);
        rstN = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        checkOutput("noDoneAfterRst", doneDef, 0);

        // recovery after reset
        applyStimulus(16'd65535, 8'd255);
        waitDone(0, 40, 1'b0, edges, clocks, heldOk);
        checkOutput("latRecover", edges, 16);
        checkOutput("quotRecover", qDef, 257);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
